// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: register map, status bit positions,
// frame FSM states and the frame-length helper.
package spi_target_pkg;

  localparam logic [2:0] REG_TX_LO  = 3'd0;
  localparam logic [2:0] REG_TX_HI  = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_RX_LO  = 3'd4;
  localparam logic [2:0] REG_RX_HI  = 3'd5;

  localparam int CTRL_W16   = 2;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_RXRDY = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_FERR  = 3;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} fsm_e;

  function automatic logic [4:0] frame_len(input logic w16);
    return w16 ? 5'd16 : 5'd8;
  endfunction

endpackage

// File: rtl/spi_target_if.sv
// Register-bus and SPI pin bundle for the SPI target; the slave modport is
// the peripheral side, the master modport is the CPU/controller side.
interface spi_target_if;
  logic       enable;
  logic       write_enable;
  logic [2:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rx_ready;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_miso;
  logic       spi_miso_oe;

  modport master (
    output enable, write_enable, address, data_in, spi_sclk, spi_mosi, spi_cs_n,
    input  data_out, rx_ready, spi_miso, spi_miso_oe
  );

  modport slave (
    input  enable, write_enable, address, data_in, spi_sclk, spi_mosi, spi_cs_n,
    output data_out, rx_ready, spi_miso, spi_miso_oe
  );
endinterface

// File: rtl/spi_target_sync.sv
// Multi-flop synchronizer bringing one asynchronous SPI pin into raw_clk.
module spi_target_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= '0;
    else         ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI target, mode 0, MSB first, 8/16-bit frames, with a register-bus front end.
// Define SPI_TARGET_FIFO_EN for a FIFO_DEPTH-entry rx FIFO instead of one holding register.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic         raw_clk,
  input logic         reset_n,
  spi_target_if.slave bus
);

  if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("spi_target: SYNC_STAGES must be >= 2 and FIFO_DEPTH a power of 2 >= 2");
  end

  logic sclk_s, mosi_s, cs_n_s;
  logic sclk_q, cs_n_q;

  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk_i(raw_clk), .rst_ni(reset_n), .d_i(bus.spi_sclk), .q_o(sclk_s));
  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk_i(raw_clk), .rst_ni(reset_n), .d_i(bus.spi_mosi), .q_o(mosi_s));
  spi_target_sync #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk_i(raw_clk), .rst_ni(reset_n), .d_i(bus.spi_cs_n), .q_o(cs_n_s));

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q <= 1'b0;
      cs_n_q <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      cs_n_q <= cs_n_s;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = cs_n_q & ~cs_n_s;
  assign cs_rise   = ~cs_n_q & cs_n_s;

  logic [15:0] tx_q;
  logic        w16_q, ferr_q, ovr_q;
  logic [7:0]  data_out_q;

  fsm_e        state_q;
  logic        miso_oe_q, wide_q, push_q, ferr_set_q;
  logic [15:0] shift_q, push_data_q;
  logic [14:0] rx_sh_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] rx_word_d;

  assign rx_word_d = {rx_sh_q, mosi_s};

  // The fall right after a frame boundary must not shift: the reload already
  // put the next frame's MSB on miso.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      miso_oe_q   <= 1'b0;
      wide_q      <= 1'b0;
      shift_q     <= '0;
      rx_sh_q     <= '0;
      bit_cnt_q   <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ferr_set_q  <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_oe_q <= 1'b0;
          if (cs_fall) state_q <= LOAD;
        end
        LOAD: begin
          if (cs_rise) begin
            miso_oe_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            wide_q    <= w16_q;
            shift_q   <= tx_q;
            bit_cnt_q <= '0;
            miso_oe_q <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if (bit_cnt_q != '0) ferr_set_q <= 1'b1;
            bit_cnt_q <= '0;
            miso_oe_q <= 1'b0;
            state_q   <= IDLE;
          end else if (sclk_rise) begin
            rx_sh_q <= rx_word_d[14:0];
            if (bit_cnt_q + 5'd1 == frame_len(wide_q)) begin
              push_q      <= 1'b1;
              push_data_q <= wide_q ? rx_word_d : {8'h00, rx_word_d[7:0]};
              shift_q     <= tx_q;
              wide_q      <= w16_q;
              bit_cnt_q   <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end else if (sclk_fall && bit_cnt_q != '0) begin
            shift_q <= {shift_q[14:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic        rd, pop, push_ok, rx_valid, ovr_evt;
  logic [15:0] rx_head;

  assign rd  = bus.enable & ~bus.write_enable;
  assign pop = rd && (bus.address == REG_RX_LO) && rx_valid;

`ifdef SPI_TARGET_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [15:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  // A pop in the same cycle frees the slot the incoming frame needs.
  assign push_ok = push_q && ((count_q != (PTR_W+1)'(FIFO_DEPTH)) || pop);

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rx_valid = (count_q != '0);
  assign rx_head  = mem_q[rd_ptr_q];
`else
  logic [15:0] hold_q;
  logic        valid_q;

  assign push_ok = push_q && (!valid_q || pop);

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push_ok) begin
      hold_q  <= push_data_q;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign rx_valid = valid_q;
  assign rx_head  = hold_q;
`endif

  assign ovr_evt = push_q && !push_ok;

  logic [7:0] status_d;
  assign status_d = {4'b0000, ferr_q, ovr_q, rx_valid, state_q != IDLE};

  // Flag set events win over a same-cycle write-1-to-clear.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_q       <= '0;
      w16_q      <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      if (bus.write_enable) begin
        case (bus.address)
          REG_TX_LO:  tx_q[7:0]  <= bus.data_in;
          REG_TX_HI:  tx_q[15:8] <= bus.data_in;
          REG_CTRL:   w16_q      <= bus.data_in[CTRL_W16];
          REG_STATUS: begin
            if (bus.data_in[STAT_FERR]) ferr_q <= 1'b0;
            if (bus.data_in[STAT_OVR])  ovr_q  <= 1'b0;
          end
          default: ;
        endcase
      end
      if (ferr_set_q) ferr_q <= 1'b1;
      if (ovr_evt)    ovr_q  <= 1'b1;
      if (rd) begin
        case (bus.address)
          REG_TX_LO:  data_out_q <= tx_q[7:0];
          REG_TX_HI:  data_out_q <= tx_q[15:8];
          REG_CTRL:   data_out_q <= {5'b00000, w16_q, 2'b00};
          REG_STATUS: data_out_q <= status_d;
          REG_RX_LO:  data_out_q <= rx_head[7:0];
          REG_RX_HI:  data_out_q <= rx_head[15:8];
          default:    data_out_q <= '0;
        endcase
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.rx_ready    = rx_valid;
  assign bus.spi_miso_oe = miso_oe_q;
  assign bus.spi_miso    = miso_oe_q & (wide_q ? shift_q[15] : shift_q[7]);

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: an SPI controller model plus register-bus tasks, checked
// against a queue-based model of received frames and status flags.
module tb_spi_target;

  localparam int HALF = 8;
`ifdef SPI_TARGET_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [2:0] A_TXL = 3'd0, A_TXH = 3'd1, A_CTRL = 3'd2, A_STAT = 3'd3, A_RXL = 3'd4, A_RXH = 3'd5;

  logic raw_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 raw_clk = ~raw_clk;

  spi_target_if bus();

  spi_target #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .raw_clk (raw_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_q[$];
  logic [15:0] m_tx;
  logic        m_w16, m_ovr, m_ferr;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge raw_clk);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_tx = '0; m_w16 = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge raw_clk);
    bus.enable = 1'b1; bus.write_enable = 1'b1; bus.address = a; bus.data_in = d;
    @(negedge raw_clk);
    bus.enable = 1'b0; bus.write_enable = 1'b0;
    case (a)
      A_TXL:  m_tx[7:0]  = d;
      A_TXH:  m_tx[15:8] = d;
      A_CTRL: m_w16      = d[2];
      A_STAT: begin
        if (d[3]) m_ferr = 1'b0;
        if (d[2]) m_ovr  = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge raw_clk);
    bus.enable = 1'b1; bus.write_enable = 1'b0; bus.address = a;
    @(negedge raw_clk);
    d = bus.data_out;
    bus.enable = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic busy);
    logic [7:0] d;
    reg_read(A_STAT, d);
    check(tag, d, {12'h000, m_ferr, m_ovr, m_q.size() != 0, busy});
  endtask

  task automatic read_rx_hi(input string tag);
    logic [7:0] d;
    reg_read(A_RXH, d);
    if (m_q.size() > 0) check(tag, d, m_q[0][15:8]);
  endtask

  task automatic read_rx_lo(input string tag);
    logic [7:0] d;
    reg_read(A_RXL, d);
    if (m_q.size() > 0) begin
      check(tag, d, m_q[0][7:0]);
      void'(m_q.pop_front());
    end
  endtask

  task automatic drain(input string tag);
    while (m_q.size() > 0) begin
      read_rx_hi({tag, "_rxhi"});
      read_rx_lo({tag, "_rxlo"});
    end
    check({tag, "_rdy_empty"}, bus.rx_ready, 1'b0);
  endtask

  task automatic cs_low();
    @(negedge raw_clk);
    bus.spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  // Mode 0: mosi changes while sclk is low, both sides sample on the rising edge.
  task automatic spi_bits(input int n, input logic [15:0] mo, output logic [15:0] mi);
    mi = '0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge raw_clk);
      bus.spi_mosi = mo[i];
      wait_clk(HALF);
      mi[i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      wait_clk(HALF);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input string tag, input logic [15:0] mo);
    logic [15:0] mi;
    int bits;
    bits = m_w16 ? 16 : 8;
    spi_bits(bits, mo, mi);
    check({tag, "_miso"}, mi, m_w16 ? m_tx : {8'h00, m_tx[7:0]});
    if (m_q.size() < DEPTH) m_q.push_back(m_w16 ? mo : {8'h00, mo[7:0]});
    else                    m_ovr = 1'b1;
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] junk;
    bus.enable = 1'b0; bus.write_enable = 1'b0; bus.address = '0; bus.data_in = '0;
    bus.spi_sclk = 1'b0; bus.spi_mosi = 1'b0; bus.spi_cs_n = 1'b1;
    model_reset();

    wait_clk(4);
    #1;
    check("rst_data_out", bus.data_out, 8'h00);
    check("rst_rx_ready", bus.rx_ready, 1'b0);
    check("rst_miso",     bus.spi_miso, 1'b0);
    check("rst_miso_oe",  bus.spi_miso_oe, 1'b0);
    @(negedge raw_clk);
    reset_n = 1'b1;
    wait_clk(4);
    check_status("rst_status", 1'b0);

    // 8-bit frame, tx 0xA5, controller sends 0x3C
    reg_write(A_TXL, 8'hA5);
    reg_write(A_CTRL, 8'h00);
    cs_low();
    check("a_miso_oe", bus.spi_miso_oe, 1'b1);
    check_status("a_busy", 1'b1);
    frame("a", 16'h003C);
    cs_high();
    check("a_oe_off", bus.spi_miso_oe, 1'b0);
    check("a_rdy", bus.rx_ready, 1'b1);
    check_status("a_status", 1'b0);
    read_rx_lo("a_rxlo");
    check("a_rdy_pop", bus.rx_ready, 1'b0);

    // 16-bit frame, tx 0x1234, controller sends 0xBEEF
    reg_write(A_TXL, 8'h34);
    reg_write(A_TXH, 8'h12);
    reg_write(A_CTRL, 8'h04);
    cs_low();
    frame("b", 16'hBEEF);
    cs_high();
    read_rx_hi("b_rxhi");
    check("b_rdy_nopop", bus.rx_ready, 1'b1);
    read_rx_lo("b_rxlo");
    check("b_rdy_pop", bus.rx_ready, 1'b0);

    // Two back-to-back 8-bit frames under one chip select
    reg_write(A_CTRL, 8'h00);
    reg_write(A_TXL, 8'h5A);
    cs_low();
    frame("c1", 16'h0011);
    frame("c2", 16'h0022);
    cs_high();
    check_status("c_status", 1'b0);
    drain("c");
    reg_write(A_STAT, 8'h04);
    check_status("c_ovr_clr", 1'b0);

    // Partial frame: keep one frame stored, then abort after 5 bits
    reg_write(A_TXL, 8'hC6);
    cs_low();
    frame("d_full", 16'h0077);
    cs_high();
    cs_low();
    spi_bits(5, 16'h001F, junk);
    cs_high();
    m_ferr = 1'b1;
    check_status("d_ferr", 1'b0);
    reg_write(A_STAT, 8'h08);
    check_status("d_ferr_clr", 1'b0);
    drain("d");

    // Five separate frames left unread
    for (int i = 0; i < 5; i++) begin
      cs_low();
      frame("e", 16'(8'h40 + i));
      cs_high();
    end
    check_status("e_status", 1'b0);
    drain("e");
    reg_write(A_STAT, 8'h0C);
    check_status("e_clr", 1'b0);

    // Randomized frames, widths and read-back patterns
    for (int it = 0; it < 10; it++) begin
      int nfr;
      reg_write(A_TXL, 8'($urandom));
      reg_write(A_TXH, 8'($urandom));
      reg_write(A_CTRL, $urandom_range(0, 1) != 0 ? 8'h04 : 8'h00);
      nfr = $urandom_range(1, 3);
      cs_low();
      for (int f = 0; f < nfr; f++) frame("rnd", 16'($urandom));
      cs_high();
      check_status("rnd_status", 1'b0);
      if ($urandom_range(0, 1) != 0) drain("rnd");
      if ($urandom_range(0, 1) != 0) begin
        reg_write(A_STAT, 8'h0C);
        check_status("rnd_clr", 1'b0);
      end
    end
    drain("rnd_end");

    // Reset in the middle of a frame
    reg_write(A_TXL, 8'h96);
    cs_low();
    frame("g_pre", 16'h0055);
    cs_high();
    check_status("g_pre_status", 1'b0);
    cs_low();
    spi_bits(3, 16'h0005, junk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("g_oe", bus.spi_miso_oe, 1'b0);
    check("g_rdy", bus.rx_ready, 1'b0);
    check("g_data_out", bus.data_out, 8'h00);
    wait_clk(3);
    bus.spi_cs_n = 1'b1;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(HALF);
    check_status("g_status", 1'b0);
    reg_write(A_TXL, 8'hC3);
    cs_low();
    frame("g_post", 16'h00E1);
    cs_high();
    read_rx_lo("g_post_rxlo");
    check("g_post_rdy", bus.rx_ready, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
